// File: rtl/xeng_pkg.sv
// Shared constants, helpers and FSM encoding for the X-engine accumulation controller.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package xeng_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } xeng_state_t;

  // Ceiling log2; minimum result of 1 so a counter is always at least one bit wide.
  function automatic int xeng_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

  // Baseline steps per channel: every antenna pairs with half the array plus itself.
  function automatic int xeng_bl_cycle(input int n_ants);
    return n_ants * (n_ants / 2 + 1);
  endfunction

  // Baseline-step beats per spectrum.
  function automatic int xeng_beats(input int n_ants, input int n_chans);
    return n_chans * xeng_bl_cycle(n_ants);
  endfunction

endpackage

// File: rtl/xeng_dump_hs.sv
// Single-entry holding register for completed banks awaiting readout, with sticky overflow.
// Latency: push or accept seen at cycle T is reflected on the outputs at T+1.
// Backpressure: a push while an entry is held and not being accepted is dropped and sets overflow.
module xeng_dump_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_bank,
  input  logic clr_ovf,
  input  logic dump_ready,
  output logic dump_valid,
  output logic dump_bank,
  output logic overflow
);

  logic valid_q, valid_d;
  logic bank_q, bank_d;
  logic ovf_q, ovf_d;
  logic accept;

  assign accept = valid_q && dump_ready;

  // Next-state: an accept frees the slot this cycle, so a coincident push replaces the entry.
  always_comb begin
    valid_d = valid_q;
    bank_d  = bank_q;
    ovf_d   = ovf_q;
    if (accept) begin
      valid_d = 1'b0;
    end
    if (push) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        bank_d  = push_bank;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bank_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bank_q  <= bank_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_bank  = bank_q;
  assign overflow   = ovf_q;

endmodule

// File: rtl/xeng_acc_ctrl.sv
// X-engine sequencer: drives bl_order_gen sync/en, accumulator first/last, bank flip and dump hand-off.
// Latency: every output is registered, 1 cycle after the inputs that cause it.
// Backpressure: readout stalls via dump_ready; an unaccepted dump at the next boundary sets overflow.
module xeng_acc_ctrl
  import xeng_pkg::*;
#(
  parameter int N_ANTS  = 16,
  parameter int N_CHANS = 128,
  parameter int ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  input  logic             din_valid,
  input  logic [ACC_W-1:0] acc_len_cfg,
  input  logic             dump_ready,
  output logic             bl_sync,
  output logic             bl_en,
  output logic             acc_first,
  output logic             acc_last,
  output logic             bank,
  output logic             dump_valid,
  output logic             dump_bank,
  output logic             overflow,
  output logic [ACC_W-1:0] spec_cnt
);

  localparam int BEATS  = xeng_beats(N_ANTS, N_CHANS);
  localparam int BEAT_W = xeng_clog2(BEATS);

  xeng_state_t      state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ACC_W-1:0] spec_cnt_q, spec_cnt_d;
  logic [ACC_W-1:0] acc_len_q, acc_len_d;
  logic             bank_q, bank_d;
  logic             bl_sync_q, bl_sync_d;
  logic             bl_en_q, bl_en_d;
  logic             acc_first_q, acc_first_d;
  logic             acc_last_q, acc_last_d;

  logic             push;
  logic             clr_ovf;
  logic [ACC_W-1:0] cfg_len;
  logic             beat_last;
  logic             spec_last;

  // A zero length would never reach a boundary; run it as single-spectrum accumulation.
  assign cfg_len   = (acc_len_cfg == '0) ? ACC_W'(1) : acc_len_cfg;
  assign beat_last = (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign spec_last = (spec_cnt_q == (acc_len_q - ACC_W'(1)));

  // FSM next-state, counters and output qualifiers; sync_in outranks a valid beat.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    spec_cnt_d  = spec_cnt_q;
    acc_len_d   = acc_len_q;
    bank_d      = bank_q;
    bl_sync_d   = 1'b0;
    bl_en_d     = 1'b0;
    acc_first_d = 1'b0;
    acc_last_d  = 1'b0;
    push        = 1'b0;
    clr_ovf     = 1'b0;
    if (sync_in) begin
      state_d    = ST_RUN;
      bl_sync_d  = 1'b1;
      beat_cnt_d = '0;
      spec_cnt_d = '0;
      acc_len_d  = cfg_len;
      bank_d     = 1'b0;
      clr_ovf    = 1'b1;
    end else if (state_q == ST_RUN && din_valid) begin
      bl_en_d     = 1'b1;
      acc_first_d = (spec_cnt_q == '0);
      acc_last_d  = spec_last;
      if (beat_last) begin
        beat_cnt_d = '0;
        if (spec_last) begin
          spec_cnt_d = '0;
          bank_d     = ~bank_q;
          acc_len_d  = cfg_len;
          push       = 1'b1;
        end else begin
          spec_cnt_d = spec_cnt_q + ACC_W'(1);
        end
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      spec_cnt_q  <= '0;
      acc_len_q   <= ACC_W'(1);
      bank_q      <= 1'b0;
      bl_sync_q   <= 1'b0;
      bl_en_q     <= 1'b0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      spec_cnt_q  <= spec_cnt_d;
      acc_len_q   <= acc_len_d;
      bank_q      <= bank_d;
      bl_sync_q   <= bl_sync_d;
      bl_en_q     <= bl_en_d;
      acc_first_q <= acc_first_d;
      acc_last_q  <= acc_last_d;
    end
  end

  // The completing bank is the one active before the toggle.
  xeng_dump_hs u_dump_hs (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_bank  (bank_q),
    .clr_ovf    (clr_ovf),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_bank  (dump_bank),
    .overflow   (overflow)
  );

  assign bl_sync   = bl_sync_q;
  assign bl_en     = bl_en_q;
  assign acc_first = acc_first_q;
  assign acc_last  = acc_last_q;
  assign bank      = bank_q;
  assign spec_cnt  = spec_cnt_q;

endmodule

// File: tb/tb_xeng_acc_ctrl.sv
// Directed bench for xeng_acc_ctrl with N_ANTS=4, N_CHANS=2 (24 beats per spectrum).
// Latency: checks outputs #1 after the edge that registered the inputs applied before it.
// Backpressure: dump_ready is driven per step to exercise hold, accept and replace.
module tb_xeng_acc_ctrl;

  localparam int ACC_W = 16;
  localparam int SPB   = 24;

  logic             clk;
  logic             rst_n;
  logic             sync_in;
  logic             din_valid;
  logic [ACC_W-1:0] acc_len_cfg;
  logic             dump_ready;
  logic             bl_sync;
  logic             bl_en;
  logic             acc_first;
  logic             acc_last;
  logic             bank;
  logic             dump_valid;
  logic             dump_bank;
  logic             overflow;
  logic [ACC_W-1:0] spec_cnt;

  int vectors = 0;
  int errs    = 0;

  xeng_acc_ctrl #(.N_ANTS(4), .N_CHANS(2), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_in     (sync_in),
    .din_valid   (din_valid),
    .acc_len_cfg (acc_len_cfg),
    .dump_ready  (dump_ready),
    .bl_sync     (bl_sync),
    .bl_en       (bl_en),
    .acc_first   (acc_first),
    .acc_last    (acc_last),
    .bank        (bank),
    .dump_valid  (dump_valid),
    .dump_bank   (dump_bank),
    .overflow    (overflow),
    .spec_cnt    (spec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, bl_sync, bl_en, acc_first, acc_last, bank, dump_valid, dump_bank, overflow, spec_cnt};
  endfunction

  // One valid beat b (counted from the last sync) for accumulation length L.
  task automatic beat(input int b, input int len);
    int sb;
    din_valid = 1'b1;
    sync_in   = 1'b0;
    tick();
    sb = (b / SPB) % len;
    chk($sformatf("bl_sync b%0d", b), 32'(bl_sync), 32'd0);
    chk($sformatf("bl_en b%0d", b), 32'(bl_en), 32'd1);
    chk($sformatf("first b%0d", b), 32'(acc_first), 32'(sb == 0));
    chk($sformatf("last b%0d", b), 32'(acc_last), 32'(sb == len - 1));
    chk($sformatf("spec b%0d", b), 32'(spec_cnt), 32'(((b + 1) / SPB) % len));
    chk($sformatf("bank b%0d", b), 32'(bank), 32'(((b + 1) / (SPB * len)) % 2));
  endtask

  task automatic do_sync(input int cfg, input logic dv);
    sync_in     = 1'b1;
    din_valid   = dv;
    acc_len_cfg = ACC_W'(cfg);
    tick();
    sync_in = 1'b0;
    chk("sync bl_sync", 32'(bl_sync), 32'd1);
    chk("sync bl_en", 32'(bl_en), 32'd0);
    chk("sync spec", 32'(spec_cnt), 32'd0);
    chk("sync bank", 32'(bank), 32'd0);
    chk("sync ovf", 32'(overflow), 32'd0);
  endtask

  initial begin
    int v;
    rst_n = 1'b0; sync_in = 1'b0; din_valid = 1'b0; acc_len_cfg = '0; dump_ready = 1'b0;
    repeat (3) tick();
    chk("reset outs", all_outs(), 32'd0);
    rst_n = 1'b1;

    // Idle: valid data without sync is ignored.
    din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle outs %0d", i), all_outs(), 32'd0);
    end

    // Length 3 accumulation, first boundary hands bank 0 to readout.
    do_sync(3, 1'b0);
    for (int b = 0; b < 72; b++) begin
      beat(b, 3);
      chk($sformatf("dv1 b%0d", b), 32'(dump_valid), 32'(b == 71));
    end
    chk("dump_bank 1st", 32'(dump_bank), 32'd0);

    // Second boundary with dump still pending: overflow, bank 0 held.
    for (int b = 72; b < 144; b++) begin
      beat(b, 3);
      chk($sformatf("dv2 b%0d", b), 32'(dump_valid), 32'd1);
      chk($sformatf("ovf2 b%0d", b), 32'(overflow), 32'(b == 143));
    end
    chk("dump_bank ovf", 32'(dump_bank), 32'd0);

    // Accept the pending dump, then resync clears overflow.
    din_valid = 1'b0; dump_ready = 1'b1;
    tick();
    dump_ready = 1'b0;
    chk("accept dv", 32'(dump_valid), 32'd0);
    chk("accept ovf sticky", 32'(overflow), 32'd1);

    // cfg 0 behaves as length 1; acceptance coincident with the next boundary replaces.
    do_sync(0, 1'b0);
    for (int b = 0; b < 48; b++) begin
      dump_ready = (b == 47);
      beat(b, 1);
      chk($sformatf("dv3 b%0d", b), 32'(dump_valid), 32'(b >= 23));
      if (b >= 23) chk($sformatf("db3 b%0d", b), 32'(dump_bank), 32'(b == 47));
      chk($sformatf("ovf3 b%0d", b), 32'(overflow), 32'd0);
    end
    dump_ready = 1'b0;

    // Clear the dump, then stall with gaps; bank flips after exactly 24 valid beats.
    din_valid = 1'b0; dump_ready = 1'b1;
    tick();
    dump_ready = 1'b0;
    chk("accept2 dv", 32'(dump_valid), 32'd0);
    v = 0;
    while (v < 24) begin
      for (int k = 0; k < 5 && v < 24; k++) begin
        beat(48 + v, 1);
        v++;
      end
      din_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
        tick();
        chk($sformatf("gap en v%0d", v), 32'(bl_en), 32'd0);
        chk($sformatf("gap first/last v%0d", v), 32'({acc_first, acc_last}), 32'd0);
        chk($sformatf("gap bank v%0d", v), 32'(bank), 32'(v == 24));
        chk($sformatf("gap dv v%0d", v), 32'(dump_valid), 32'(v == 24));
      end
    end
    chk("gap dump_bank", 32'(dump_bank), 32'd0);

    // Sync mid-accumulation with valid data: counters clear, pending dump survives.
    do_sync(3, 1'b0);
    for (int b = 0; b < 30; b++) beat(b, 3);
    chk("mid spec", 32'(spec_cnt), 32'd1);
    do_sync(3, 1'b1);
    chk("mid first", 32'(acc_first), 32'd0);
    chk("mid dv kept", 32'(dump_valid), 32'd1);
    chk("mid db kept", 32'(dump_bank), 32'd0);

    // Reset mid-accumulation discards everything and returns to idle.
    for (int b = 0; b < 5; b++) beat(b, 3);
    rst_n = 1'b0;
    tick();
    chk("rst mid outs", all_outs(), 32'd0);
    rst_n = 1'b1; din_valid = 1'b1;
    tick();
    chk("post rst idle", all_outs(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
